// File: rtl/freq_meter_if.sv
// Signal bundle between a frequency meter and whoever drives/observes it.
// There is no backpressure: freq_valid is a one-cycle pulse, and the sink
// must capture freq_out/overflow on that cycle (they then hold until the
// next completed window or reset). state_dbg mirrors the FSM encoding.
interface freq_meter_if #(
  parameter int CNT_W = 28
);
  logic             sig_in;
  logic             enable;
  logic [CNT_W-1:0] freq_out;
  logic             freq_valid;
  logic             overflow;
  logic             busy;
  logic [1:0]       state_dbg;

  modport master (
    output sig_in, enable,
    input  freq_out, freq_valid, overflow, busy, state_dbg
  );

  modport slave (
    input  sig_in, enable,
    output freq_out, freq_valid, overflow, busy, state_dbg
  );
endinterface

// File: rtl/freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of sig_in over a
// window of GATE_CYCLES clk_in cycles, then publishes the count for one
// LATCH cycle. Windows repeat back-to-back while enable stays high.
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 28
) (
  input  logic        clk_in,
  input  logic        rst_n,
  freq_meter_if.slave bus
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_NEAR  = CNT_MAX - 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LATCH   = 2'd2
  } state_t;

  state_t           state;
  logic             sync1, sync2, sync3;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic             ovf;
  logic [CNT_W-1:0] freq_q;
  logic             valid_q;
  logic             ovf_out_q;
  logic             busy_q;

  logic             rise;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;

  // Two flops resynchronize sig_in; the third only delays for edge detection.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= bus.sig_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Saturating edge count for this cycle; ovf latches once the count hits max.
  always_comb begin
    rise     = sync2 & ~sync3;
    cnt_next = edge_cnt;
    ovf_next = ovf;
    if (rise) begin
      if (edge_cnt != CNT_MAX) cnt_next = edge_cnt + 1'b1;
      if (edge_cnt >= CNT_NEAR) ovf_next = 1'b1;
    end
  end

  // Window FSM. The result is registered on the edge entering LATCH so that
  // freq_out/overflow already show the new value while freq_valid is high.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      ovf       <= 1'b0;
      freq_q    <= '0;
      valid_q   <= 1'b0;
      ovf_out_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf      <= 1'b0;
          valid_q  <= 1'b0;
          if (bus.enable) begin
            state  <= MEASURE;
            busy_q <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        MEASURE: begin
          if (!bus.enable) begin
            // Abort: partial count is discarded, published result untouched.
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
            busy_q   <= 1'b0;
          end else if (gate_cnt == GATE_LAST) begin
            // Final window cycle: include an edge seen on this very cycle.
            state     <= LATCH;
            freq_q    <= cnt_next;
            ovf_out_q <= ovf_next;
            valid_q   <= 1'b1;
            busy_q    <= 1'b0;
            gate_cnt  <= '0;
            edge_cnt  <= '0;
            ovf       <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
            edge_cnt <= cnt_next;
            ovf      <= ovf_next;
          end
        end
        LATCH: begin
          // Edges seen here belong to no window and are dropped.
          valid_q  <= 1'b0;
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf      <= 1'b0;
          if (bus.enable) begin
            state  <= MEASURE;
            busy_q <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          gate_cnt <= '0;
          edge_cnt <= '0;
          ovf      <= 1'b0;
          valid_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.freq_out   = freq_q;
  assign bus.freq_valid = valid_q;
  assign bus.overflow   = ovf_out_q;
  assign bus.busy       = busy_q;
  assign bus.state_dbg  = state;

endmodule
